// File: rtl/fp_normalize_round.sv
// ----------------------------------------------------------------------------
// fp_normalize_round
//   Post-add normaliser/rounder for the floating-point add/sub datapath.
//   It accepts a raw significand sum with carry-out and guard/round/sticky
//   bits, together with a tentative exponent and the result sign. It shifts
//   iteratively to normalise, rounds to nearest-even, handles zero, overflow
//   and subnormal results, and presents the packed result over valid/ready.
//
//   Ports
//     clk        clock, all state updates on the rising edge
//     rst_n      asynchronous active-low reset
//     in_valid   raw result available
//     in_ready   block can accept a new raw result (high only in IDLE)
//     in_sign    result sign
//     in_exp     tentative biased exponent
//     in_mant    [MANT_W+3]=carry, [MANT_W+2]=hidden, [MANT_W+1:3]=fraction,
//                [2]=G, [1]=R, [0]=S
//     out_valid  result valid; held until out_ready
//     out_ready  consumer accepts the result
//     out_sign   result sign
//     out_exp    normalised biased exponent
//     out_mant   normalised significand, hidden bit at [MANT_W-1]
//     out_flags  {overflow, underflow, inexact}; present only when the
//                macro FPNORM_FLAGS_EN is defined
//
//   Optional feature macro: FPNORM_FLAGS_EN
// ----------------------------------------------------------------------------
module fp_normalize_round #(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sign,
  input  logic [EXP_W-1:0]    in_exp,
  input  logic [MANT_W+3:0]   in_mant,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sign,
  output logic [EXP_W-1:0]    out_exp,
`ifdef FPNORM_FLAGS_EN
  output logic [MANT_W-1:0]   out_mant,
  output logic [2:0]          out_flags
`else
  output logic [MANT_W-1:0]   out_mant
`endif
);

  localparam int RAW_W = MANT_W + 4;
  localparam logic [EXP_W-1:0] EXP_MAX  = '1;
  localparam logic [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic [EXP_W-1:0] EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic                sign_r;
  logic [EXP_W-1:0]    exp_r;
  logic [RAW_W-1:0]    mant_r;
`ifdef FPNORM_FLAGS_EN
  logic                inexact_r;
  logic                ovf_r;
`endif

  // Exponent increment that sticks at the all-ones (infinity) code so a
  // carry on an already-infinite exponent cannot wrap back to zero.
  function automatic logic [EXP_W-1:0] exp_inc_sat(input logic [EXP_W-1:0] e);
    return (e == EXP_MAX) ? EXP_MAX : e + EXP_ONE;
  endfunction

  // Round-to-nearest-even on G/R/S; result carries one extra MSB so a
  // significand overflow to 2^MANT_W is visible to the caller.
  function automatic logic [MANT_W:0] round_rne(input logic [RAW_W-1:0] m);
    logic inc;
    inc = m[2] & (m[1] | m[0] | m[3]);
    return {1'b0, m[RAW_W-2:3]} + {{MANT_W{1'b0}}, inc};
  endfunction

  // Normalise decision inputs
  logic n_carry, n_zero, n_hidden, n_floor, n_emax;
  assign n_carry  = mant_r[RAW_W-1];
  assign n_zero   = (mant_r == '0);
  assign n_hidden = mant_r[RAW_W-2];
  assign n_floor  = (exp_r <= EXP_ONE);
  assign n_emax   = (exp_r == EXP_MAX);

  // One normalisation step
  logic [EXP_W-1:0] norm_exp;
  logic [RAW_W-1:0] norm_mant;

  always_comb begin
    norm_exp  = exp_r;
    norm_mant = mant_r;
    if (n_carry) begin
      // Right shift folds the dropped R bit into sticky.
      norm_mant = {1'b0, mant_r[RAW_W-1:2], mant_r[1] | mant_r[0]};
      norm_exp  = exp_inc_sat(exp_r);
    end else if (n_zero) begin
      norm_exp  = EXP_ZERO;
    end else if (n_hidden) begin
      norm_exp  = exp_r;
    end else if (n_floor) begin
      // Subnormal: exponent 1 and 0 share the same scale, so no shift.
      norm_exp  = EXP_ZERO;
    end else if (n_emax) begin
      norm_exp  = exp_r;
    end else begin
      norm_mant = {mant_r[RAW_W-2:0], 1'b0};
      norm_exp  = exp_r - EXP_ONE;
    end
  end

  // Rounding step
  logic [MANT_W:0]   rnd_sum;
  logic [MANT_W-1:0] rnd_sig;
  logic [EXP_W-1:0]  rnd_exp;

  always_comb begin
    rnd_sum = round_rne(mant_r);
    if (rnd_sum[MANT_W]) begin
      rnd_sig = rnd_sum[MANT_W:1];
      rnd_exp = exp_inc_sat(exp_r);
    end else begin
      rnd_sig = rnd_sum[MANT_W-1:0];
      // Rounding a subnormal up into the hidden bit promotes it to normal.
      rnd_exp = ((exp_r == EXP_ZERO) && rnd_sum[MANT_W-1]) ? EXP_ONE : exp_r;
    end
    if (rnd_exp == EXP_MAX) begin
      rnd_sig = '0;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) state_nxt = NORM;
      end
      NORM: begin
        if (n_carry)                            state_nxt = ROUND;
        else if (n_zero)                        state_nxt = DONE;
        else if (n_hidden || n_floor || n_emax) state_nxt = ROUND;
        else                                    state_nxt = NORM;
      end
      ROUND: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state == IDLE);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r    <= 1'b0;
      exp_r     <= '0;
      mant_r    <= '0;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_mant  <= '0;
`ifdef FPNORM_FLAGS_EN
      inexact_r <= 1'b0;
      ovf_r     <= 1'b0;
      out_flags <= '0;
`endif
    end else begin
      case (state)
        // Capture the raw result
        IDLE: begin
          if (in_valid) begin
            sign_r    <= in_sign;
            exp_r     <= in_exp;
            mant_r    <= in_mant;
`ifdef FPNORM_FLAGS_EN
            inexact_r <= 1'b0;
            ovf_r     <= 1'b0;
`endif
          end
        end
        // Normalise one position per cycle
        NORM: begin
          exp_r  <= norm_exp;
          mant_r <= norm_mant;
        end
        // Round and resolve overflow / subnormal promotion
        ROUND: begin
          exp_r     <= rnd_exp;
          mant_r    <= {1'b0, rnd_sig, 3'b000};
`ifdef FPNORM_FLAGS_EN
          inexact_r <= |mant_r[2:0];
          ovf_r     <= (rnd_exp == EXP_MAX);
`endif
        end
        // Present the result and hold it until the consumer takes it
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_sign  <= sign_r;
            out_exp   <= exp_r;
            out_mant  <= mant_r[RAW_W-2:3];
`ifdef FPNORM_FLAGS_EN
            out_flags <= {ovf_r, (exp_r == EXP_ZERO) && inexact_r, inexact_r};
`endif
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
